// File: rtl/quotient_bcd_converter.sv
// quotient_bcd_converter
//   Takes N-bit unsigned quotients from the non-restoring divider and converts
//   each one to packed BCD with a sequential double-dabble engine (one bit per
//   clock). A one-entry hold register absorbs a quotient that arrives while a
//   conversion is running, so the divider's single-cycle ready pulse is kept.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   ready_in   quotient-valid strobe from the divider (may be a 1-cycle pulse)
//   data_in    N-bit unsigned quotient, sampled on capture
//   accept_out quotient can be taken this cycle (~pending, combinational)
//   bcd_out    packed BCD result, digit 0 in [3:0] (registered)
//   valid_out  bcd_out holds a finished result (registered)
//   accept_in  consumer takes the result
module quotient_bcd_converter #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready_in,
  input  logic [N-1:0]          data_in,
  output logic                  accept_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid_out,
  input  logic                  accept_in
);

  localparam int W  = 4*DIGITS + N;
  localparam int CW = $clog2(N) + 1;

  // DIGITS decimal digits must cover the largest N-bit quotient.
  function automatic bit params_ok();
    longint unsigned limit;
    longint unsigned p;
    if (N < 2 || N > 62) return 1'b0;
    limit = (64'd1 << N) - 64'd1;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      p = p * 64'd10;
      if (p > limit) return 1'b1;
    end
    return 1'b0;
  endfunction

  localparam bit PARAMS_OK = params_ok();

  if (!PARAMS_OK) begin : g_param_check
    $error("quotient_bcd_converter: need N >= 2 and 10**DIGITS > 2**N - 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   sr;
  logic [CW-1:0]  count;
  logic [N-1:0]   hold;
  logic           pending;

  logic           capture;
  logic [W-1:0]   sr_adj;
  logic [W-1:0]   sr_shift;

  assign accept_out = ~pending;
  assign capture    = ready_in & ~pending;

  // Add-3 on every BCD digit >= 5; 4-bit add, so no carry between digits.
  always_comb begin
    sr_adj = sr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sr[N + 4*d +: 4] >= 4'd5)
        sr_adj[N + 4*d +: 4] = sr[N + 4*d +: 4] + 4'd3;
    end
    sr_shift = sr_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      count     <= '0;
      hold      <= '0;
      pending   <= 1'b0;
      bcd_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            sr    <= {{(4*DIGITS){1'b0}}, data_in};
            count <= CW'(N - 1);
            state <= CONVERT;
          end
        end

        CONVERT: begin
          if (capture) begin
            hold    <= data_in;
            pending <= 1'b1;
          end
          sr <= sr_shift;
          if (count == '0) begin
            bcd_out   <= sr_shift[W-1:N];
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          if (accept_in) begin
            valid_out <= 1'b0;
            // A held quotient takes priority; capture is impossible while
            // pending is set because accept_out is low.
            if (pending) begin
              sr      <= {{(4*DIGITS){1'b0}}, hold};
              pending <= 1'b0;
              count   <= CW'(N - 1);
              state   <= CONVERT;
            end else if (capture) begin
              sr    <= {{(4*DIGITS){1'b0}}, data_in};
              count <= CW'(N - 1);
              state <= CONVERT;
            end else begin
              state <= IDLE;
            end
          end else if (capture) begin
            hold    <= data_in;
            pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_bcd_converter.sv
module tb_quotient_bcd_converter;

  localparam int N      = 8;
  localparam int DIGITS = 3;

  logic                clk;
  logic                reset;
  logic                ready_in;
  logic [N-1:0]        data_in;
  logic                accept_out;
  logic [4*DIGITS-1:0] bcd_out;
  logic                valid_out;
  logic                accept_in;

  int unsigned n_checks;
  int unsigned n_fail;

  quotient_bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .accept_out (accept_out),
    .bcd_out    (bcd_out),
    .valid_out  (valid_out),
    .accept_in  (accept_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until valid_out rises (0 if it never does within budget).
  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic capture(input logic [N-1:0] v);
    ready_in = 1'b1;
    data_in  = v;
    tick();
    ready_in = 1'b0;
  endtask

  task automatic consume();
    accept_in = 1'b1;
    tick();
    accept_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    n_checks++;
    if (bcd_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bcd: got %h want 000", bcd_out);
    end
    n_checks++;
    if (accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_accept: got %b want 1", accept_out);
    end
  endtask

  task automatic test_convert(input logic [N-1:0] v, input logic [11:0] exp);
    int unsigned lat;
    int unsigned acc_bad;
    capture(v);
    acc_bad = 0;
    lat = 0;
    for (int unsigned i = 1; i <= 20; i++) begin
      if (accept_out !== 1'b1) acc_bad++;
      tick();
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != N) begin
      n_fail++;
      $display("FAIL conv_latency(%0d): got %0d edges want %0d", v, lat, N);
    end
    n_checks++;
    if (bcd_out !== exp) begin
      n_fail++;
      $display("FAIL conv_bcd(%0d): got %h want %h", v, bcd_out, exp);
    end
    n_checks++;
    if (acc_bad != 0 || accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL conv_accept_out(%0d): low on %0d cycles, now %b want 1",
               v, acc_bad, accept_out);
    end
    consume();
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_release(%0d): valid got %b want 0", v, valid_out);
    end
    // Back in IDLE: no further result should appear.
    for (int unsigned i = 0; i < 3; i++) tick();
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_idle(%0d): valid got %b want 0", v, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lat;
    capture(8'd37);        // edge t0
    tick();                // t0+1
    tick();                // t0+2
    capture(8'd200);       // t0+3, goes to hold
    n_checks++;
    if (accept_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pending: accept_out got %b want 0", accept_out);
    end
    wait_valid(lat);       // expected at t0+8
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d edges want 5", lat);
    end
    n_checks++;
    if (bcd_out !== 12'h037) begin
      n_fail++;
      $display("FAIL b2b_first_bcd: got %h want 037", bcd_out);
    end
    consume();
    n_checks++;
    if (valid_out !== 1'b0 || accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reload: valid %b accept_out %b want 0 1",
               valid_out, accept_out);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != N) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d edges want %0d", lat, N);
    end
    n_checks++;
    if (bcd_out !== 12'h200) begin
      n_fail++;
      $display("FAIL b2b_second_bcd: got %h want 200", bcd_out);
    end
    consume();
  endtask

  task automatic test_stall();
    int unsigned lat;
    int unsigned unstable;
    capture(8'd50);
    wait_valid(lat);
    n_checks++;
    if (bcd_out !== 12'h050) begin
      n_fail++;
      $display("FAIL stall_bcd: got %h want 050", bcd_out);
    end
    unstable = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (i == 3) begin
        ready_in = 1'b1;
        data_in  = 8'd77;
      end else if (i == 10) begin
        ready_in = 1'b1;
        data_in  = 8'd88;
      end else begin
        ready_in = 1'b0;
      end
      tick();
      if (valid_out !== 1'b1 || bcd_out !== 12'h050) unstable++;
    end
    ready_in = 1'b0;
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles want 0", unstable);
    end
    n_checks++;
    if (accept_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pending: accept_out got %b want 0", accept_out);
    end
    consume();
    wait_valid(lat);
    n_checks++;
    if (lat != N || bcd_out !== 12'h077) begin
      n_fail++;
      $display("FAIL stall_held: got %h after %0d edges want 077 after %0d",
               bcd_out, lat, N);
    end
    consume();
    for (int unsigned i = 0; i < 12; i++) tick();
    n_checks++;
    if (valid_out !== 1'b0 || accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ignored: valid %b accept_out %b want 0 1",
               valid_out, accept_out);
    end
  endtask

  task automatic test_simultaneous();
    int unsigned lat;
    capture(8'd5);
    wait_valid(lat);
    n_checks++;
    if (bcd_out !== 12'h005) begin
      n_fail++;
      $display("FAIL simul_first_bcd: got %h want 005", bcd_out);
    end
    accept_in = 1'b1;
    ready_in  = 1'b1;
    data_in   = 8'd128;
    tick();
    accept_in = 1'b0;
    ready_in  = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_load: valid %b accept_out %b want 0 1",
               valid_out, accept_out);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != N || bcd_out !== 12'h128) begin
      n_fail++;
      $display("FAIL simul_result: got %h after %0d edges want 128 after %0d",
               bcd_out, lat, N);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int unsigned lat;
    capture(8'd99);        // t0
    capture(8'd11);        // t0+1, held
    tick();
    tick();
    tick();                // t0+4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0 || bcd_out !== 12'h000 || accept_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: valid %b bcd %h accept_out %b want 0 000 1",
               valid_out, bcd_out, accept_out);
    end
    for (int unsigned i = 0; i < 12; i++) tick();
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_discard: valid got %b want 0", valid_out);
    end
    test_convert(8'd42, 12'h042);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    ready_in  = 1'b0;
    data_in   = '0;
    accept_in = 1'b0;
    test_reset();
    test_convert(8'd0,   12'h000);
    test_convert(8'd255, 12'h255);
    test_convert(8'd9,   12'h009);
    test_convert(8'd100, 12'h100);
    test_convert(8'd59,  12'h059);
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
